// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES constants and helpers for the key schedule, round function and
// IP/FP blocks.
//   - Width constants for the key, the C/D register and the round subkey.
//   - PC-1 (64->56) and PC-2 (56->48) selection tables.
//   - Per-round left-shift amounts SHIFTS[1:16].
//   - rot_cd(): rotates the C and D halves of a C/D word independently.
// All tables use FIPS 46 numbering, where bit 1 is the MSB. A FIPS bit n of a
// vector declared [W:1] therefore lives at index W+1-n.
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  // Key schedule controller states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  // PC-1: entry i is the key bit that becomes bit i of C0||D0
  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry j is the C||D bit that becomes bit j of the subkey
  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount applied before each round's PC-2
  localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Rotate C (bits 56:29) and D (bits 28:1) independently by one or two
  // places. "Left" moves bits toward FIPS bit 1, i.e. toward the MSB.
  function automatic logic [CD_W:1] rot_cd(input logic [CD_W:1] cd,
                                           input logic          right,
                                           input logic          two);
    logic [HALF_W:1] c;
    logic [HALF_W:1] d;
    c = cd[CD_W:HALF_W+1];
    d = cd[HALF_W:1];
    if (!right && !two) begin
      c = {c[HALF_W-1:1], c[HALF_W]};
      d = {d[HALF_W-1:1], d[HALF_W]};
    end else if (!right && two) begin
      c = {c[HALF_W-2:1], c[HALF_W:HALF_W-1]};
      d = {d[HALF_W-2:1], d[HALF_W:HALF_W-1]};
    end else if (right && !two) begin
      c = {c[1], c[HALF_W:2]};
      d = {d[1], d[HALF_W:2]};
    end else begin
      c = {c[2:1], c[HALF_W:3]};
      d = {d[2:1], d[HALF_W:3]};
    end
    return {c, d};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Combinational DES Permuted Choice 2: selects 48 of the 56 C||D bits to form
// a round subkey. Pure wiring; usable both by the iterative key schedule and
// by an unrolled pipeline.
// Ports:
//   cd     in  [56:1]  C||D register, FIPS numbering (bit 1 = MSB)
//   subkey out [48:1]  round subkey, FIPS numbering (bit 1 = MSB)
// -----------------------------------------------------------------------------
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W:1]     cd,
  output logic [SUBKEY_W:1] subkey
);

  // FIPS bit j of the subkey is FIPS bit PC2[j] of C||D
  for (genvar j = 1; j <= SUBKEY_W; j++) begin : g_pc2
    assign subkey[SUBKEY_W+1-j] = cd[CD_W+1-PC2[j]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Iterative DES key schedule. A key is loaded through PC-1 into a 56-bit C/D
// register; each accepted subkey then rotates C and D by the round's shift
// amount, and PC-2 of the register is presented as the next subkey.
// Encrypt mode streams K1..K16, decrypt mode streams K16..K1 by starting from
// the unrotated C0D0 (equal to C16D16) and rotating right.
// Ports:
//   clk      in         rising-edge clock
//   rst_n    in         asynchronous active-low reset
//   start    in         load key and begin; honoured only while idle
//   key      in  [64:1] DES key, FIPS numbering; parity bits ignored
//   decrypt  in         sampled with start: 0 = K1..K16, 1 = K16..K1
//   busy     out        schedule in progress
//   k_valid  out        k_out holds a valid subkey
//   k_ready  in         consumer accepts the subkey
//   k_out    out [48:1] current subkey, FIPS numbering
//   k_round  out [4:1]  round number of k_out (16 encoded as 0)
//   done     out        one-cycle pulse after the last subkey is accepted
// -----------------------------------------------------------------------------
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_W:1]      key,
  input  logic                decrypt,
  output logic                busy,
  output logic                k_valid,
  input  logic                k_ready,
  output logic [SUBKEY_W:1]   k_out,
  output logic [4:1]          k_round,
  output logic                done
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  ks_state_t       state;
  ks_state_t       state_next;
  logic [CD_W:1]   cd;
  logic [CD_W:1]   cd_next;
  logic [CD_W:1]   pc1_key;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic            mode;
  logic            mode_next;
  logic            done_next;
  logic [15:0]     shift_two;
  logic [3:0]      shift_idx;
  logic            two;
  logic            unused_parity;

  // PC-1 applied directly to the key port; only sampled on a load
  for (genvar i = 1; i <= CD_W; i++) begin : g_pc1
    assign pc1_key[CD_W+1-i] = key[KEY_W+1-PC1[i]];
  end

  // The eight parity bits never reach PC-1
  assign unused_parity = ^{key[57], key[49], key[41], key[33],
                           key[25], key[17], key[9],  key[1]};

  // Bit r-1 is set when round r rotates by two places
  for (genvar r = 1; r <= 16; r++) begin : g_shift
    assign shift_two[r-1] = (SHIFTS[r] == 2);
  end

  // Rotation needed to move from the current subkey to the next one.
  // Encrypt goes from round cnt+1 to cnt+2 and uses that round's shift;
  // decrypt undoes the shift of round 16-cnt, the one just presented.
  assign shift_idx = mode ? (4'd15 - cnt) : (cnt + 4'd1);
  assign two       = shift_two[shift_idx];

  // Next-state and datapath update. With k_valid high throughout RUN, a
  // transfer is simply k_ready while running.
  always_comb begin
    state_next = state;
    cd_next    = cd;
    cnt_next   = cnt;
    mode_next  = mode;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_next  = decrypt;
          cd_next    = decrypt ? pc1_key : rot_cd(pc1_key, 1'b0, shift_two[0]);
          cnt_next   = 4'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (k_ready) begin
          if (cnt == LAST_CNT) begin
            // Scrub the key material once the stream is finished
            cd_next    = '0;
            cnt_next   = 4'd0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cd_next  = rot_cd(cd, mode, two);
            cnt_next = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cd    <= '0;
      cnt   <= 4'd0;
      mode  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cd    <= cd_next;
      cnt   <= cnt_next;
      mode  <= mode_next;
      done  <= done_next;
    end
  end

  assign busy    = (state == RUN);
  assign k_valid = (state == RUN);

  // Round 16 truncates to 0 in the 4-bit field in both orders
  assign k_round = (state == RUN) ? (mode ? (4'd0 - cnt) : (cnt + 4'd1)) : 4'd0;

  des_pc2 u_pc2 (
    .cd     (cd),
    .subkey (k_out)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule
// Self-checking bench for des_key_schedule. Expected subkeys come from a
// table-driven model that computes each Ki from the key using the cumulative
// rotation count, independent of the design's iterative datapath.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1_A    = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_A    = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_A   = 48'hCB3D8B0E17F5;

  localparam int TB_PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TB_PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TB_SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [64:1] key;
  logic        decrypt;
  logic        busy;
  logic        k_valid;
  logic        k_ready;
  logic [48:1] k_out;
  logic [4:1]  k_round;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [47:0] got_key  [16];
  logic [3:0]  got_rnd  [16];
  logic [47:0] enc_keys [16];
  int          n_xfer;
  int          hold_bad;
  int          done_cnt;
  int          first_lat;
  int          last_xfer_cyc;
  bit          timed_out;
  logic        done_first;
  logic        busy_at_done;

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key     (key),
    .decrypt (decrypt),
    .busy    (busy),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .k_out   (k_out),
    .k_round (k_round),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subkey Ki: C||D is C0||D0 rotated left by the sum of the first i shifts,
  // bit p of C0||D0 is key bit PC1[p], subkey bit j is C||D bit PC2[j].
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int round);
    int          tot;
    int          p;
    int          src;
    logic [47:0] r;
    logic [63:0] t;
    tot = 0;
    for (int i = 1; i <= round; i++) tot += TB_SHIFTS[i];
    r = '0;
    for (int j = 1; j <= 48; j++) begin
      p = TB_PC2[j];
      if (p <= 28) src = TB_PC1[((p - 1 + tot) % 28) + 1];
      else         src = TB_PC1[28 + ((p - 29 + tot) % 28) + 1];
      t = k >> (64 - src);
      r = (r << 1) | {47'b0, t[0]};
    end
    return r;
  endfunction

  // Drive one full schedule with k_ready high duty% of the time; records
  // accepted subkeys, hold violations under backpressure and the done pulse.
  task automatic run_schedule(input logic [63:0] k, input bit dec, input int duty);
    logic        held;
    logic [47:0] hk;
    logic [3:0]  hr;
    bit          rdy;
    int          cyc;
    n_xfer = 0; hold_bad = 0; done_cnt = 0; first_lat = -1; last_xfer_cyc = -1;
    timed_out = 0; held = 0; hk = '0; hr = '0;
    @(negedge clk);
    key = k; decrypt = dec; start = 1'b1; k_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (n_xfer < 16 && !timed_out) begin
      if (k_valid === 1'b1) begin
        if (first_lat < 0) first_lat = cyc;
        if (held && (k_out !== hk || k_round !== hr)) hold_bad++;
        rdy = ($urandom_range(99) < duty);
        k_ready = rdy;
        if (rdy) begin
          got_key[n_xfer] = k_out;
          got_rnd[n_xfer] = k_round;
          n_xfer++;
          last_xfer_cyc = cyc;
          held = 0;
        end else begin
          held = 1; hk = k_out; hr = k_round;
        end
      end else begin
        k_ready = 1'($urandom_range(1));
        held = 0;
      end
      if (n_xfer < 16) begin
        @(negedge clk);
        cyc++;
        if (cyc > 400) timed_out = 1;
      end
    end
    done_first = 1'b0; busy_at_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        done_first   = done;
        busy_at_done = busy;
        k_ready      = 1'b0;
      end
      if (done === 1'b1) done_cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; key = '0; decrypt = 1'b0; k_ready = 1'b0;
    #12;
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (k_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_k_valid: got %b expected 0", k_valid); end
    checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (k_out !== 48'h0)   begin errors++; $display("[TB] FAIL reset_k_out: got %h expected 0", k_out); end
    checks++; if (k_round !== 4'h0)  begin errors++; $display("[TB] FAIL reset_k_round: got %h expected 0", k_round); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_encrypt;
    logic [47:0] exp;
    run_schedule(KEY_A, 1'b0, 100);
    checks++; if (timed_out)          begin errors++; $display("[TB] FAIL enc_timeout: got %0d transfers expected 16", n_xfer); end
    checks++; if (first_lat != 1)     begin errors++; $display("[TB] FAIL enc_latency: got %0d expected 1", first_lat); end
    checks++; if (last_xfer_cyc != 16) begin errors++; $display("[TB] FAIL enc_k16_cycle: got %0d expected 16", last_xfer_cyc); end
    checks++; if (got_key[0] !== K1_A)   begin errors++; $display("[TB] FAIL enc_k1_vector: got %h expected %h", got_key[0], K1_A); end
    checks++; if (got_key[1] !== K2_A)   begin errors++; $display("[TB] FAIL enc_k2_vector: got %h expected %h", got_key[1], K2_A); end
    checks++; if (got_key[15] !== K16_A) begin errors++; $display("[TB] FAIL enc_k16_vector: got %h expected %h", got_key[15], K16_A); end
    for (int i = 0; i < 16; i++) begin
      exp = ref_subkey(KEY_A, i + 1);
      enc_keys[i] = exp;
      checks++; if (got_key[i] !== exp) begin errors++; $display("[TB] FAIL enc_k%0d: got %h expected %h", i + 1, got_key[i], exp); end
      checks++; if (got_rnd[i] !== 4'(i + 1)) begin errors++; $display("[TB] FAIL enc_round%0d: got %0d expected %0d", i + 1, got_rnd[i], 4'(i + 1)); end
    end
    checks++; if (done_first !== 1'b1)   begin errors++; $display("[TB] FAIL enc_done_t17: got %b expected 1", done_first); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("[TB] FAIL enc_busy_t17: got %b expected 0", busy_at_done); end
    checks++; if (done_cnt != 1)         begin errors++; $display("[TB] FAIL enc_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_decrypt;
    run_schedule(KEY_A, 1'b1, 100);
    checks++; if (n_xfer != 16) begin errors++; $display("[TB] FAIL dec_transfers: got %0d expected 16", n_xfer); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_key[i] !== enc_keys[15 - i]) begin errors++; $display("[TB] FAIL dec_key%0d: got %h expected %h", i, got_key[i], enc_keys[15 - i]); end
      checks++; if (got_rnd[i] !== 4'(16 - i)) begin errors++; $display("[TB] FAIL dec_round%0d: got %0d expected %0d", i, got_rnd[i], 4'(16 - i)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL dec_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure;
    logic [47:0] exp;
    run_schedule(KEY_A ^ {$urandom, $urandom}, 1'b0, 40);
    run_schedule(KEY_B, 1'b1, 40);
    checks++; if (timed_out)     begin errors++; $display("[TB] FAIL bp_timeout: got %0d transfers expected 16", n_xfer); end
    checks++; if (n_xfer != 16)  begin errors++; $display("[TB] FAIL bp_transfers: got %0d expected 16", n_xfer); end
    checks++; if (hold_bad != 0) begin errors++; $display("[TB] FAIL bp_hold_stable: got %0d violations expected 0", hold_bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
    for (int i = 0; i < 16; i++) begin
      exp = ref_subkey(KEY_B, 16 - i);
      checks++; if (got_key[i] !== exp) begin errors++; $display("[TB] FAIL bp_key%0d: got %h expected %h", i, got_key[i], exp); end
    end
  endtask

  task automatic test_parity;
    run_schedule(KEY_A ^ 64'h0101010101010101, 1'b0, 100);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_key[i] !== enc_keys[i]) begin errors++; $display("[TB] FAIL parity_k%0d: got %h expected %h", i + 1, got_key[i], enc_keys[i]); end
    end
  endtask

  task automatic test_start_busy;
    logic [47:0] exp;
    int          waited;
    @(negedge clk);
    key = KEY_A; decrypt = 1'b0; start = 1'b1; k_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 4) begin
        start = 1'b1; key = KEY_B; decrypt = 1'b1;
      end
      exp = ref_subkey(KEY_A, i + 1);
      checks++; if (k_out !== exp) begin errors++; $display("[TB] FAIL busy_start_k%0d: got %h expected %h", i + 1, k_out, exp); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL busy_done: got %b expected 1", done); end
    start = 1'b1; key = KEY_B; decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp = ref_subkey(KEY_B, 1);
    checks++; if (k_valid !== 1'b1) begin errors++; $display("[TB] FAIL done_start_valid: got %b expected 1", k_valid); end
    checks++; if (k_out !== exp)    begin errors++; $display("[TB] FAIL done_start_k1: got %h expected %h", k_out, exp); end
    checks++; if (k_round !== 4'd1) begin errors++; $display("[TB] FAIL done_start_round: got %0d expected 1", k_round); end
    waited = 0;
    while (busy === 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL done_start_drain: got busy %b expected 0", busy); end
    k_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int waited;
    @(negedge clk);
    key = KEY_A; decrypt = 1'b0; start = 1'b1; k_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (k_round !== 4'd8 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (k_round !== 4'd8) begin errors++; $display("[TB] FAIL rst_mid_reach_r8: got %0d expected 8", k_round); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (k_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_k_valid: got %b expected 0", k_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (k_out !== 48'h0)  begin errors++; $display("[TB] FAIL rst_mid_k_out: got %h expected 0", k_out); end
    @(negedge clk);
    rst_n = 1'b1; k_ready = 1'b0;
    run_schedule(KEY_A, 1'b0, 100);
    checks++; if (got_key[0] !== K1_A) begin errors++; $display("[TB] FAIL rst_mid_fresh_k1: got %h expected %h", got_key[0], K1_A); end
    checks++; if (n_xfer != 16)        begin errors++; $display("[TB] FAIL rst_mid_transfers: got %0d expected 16", n_xfer); end
  endtask

  task automatic test_random;
    logic [63:0] k;
    bit          dec;
    logic [47:0] exp;
    for (int n = 0; n < 4; n++) begin
      k   = {$urandom, $urandom};
      dec = 1'($urandom_range(1));
      run_schedule(k, dec, int'($urandom_range(90, 30)));
      checks++; if (hold_bad != 0) begin errors++; $display("[TB] FAIL rand%0d_hold: got %0d violations expected 0", n, hold_bad); end
      checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL rand%0d_done: got %0d expected 1", n, done_cnt); end
      for (int i = 0; i < 16; i++) begin
        exp = ref_subkey(k, dec ? (16 - i) : (i + 1));
        checks++; if (got_key[i] !== exp) begin errors++; $display("[TB] FAIL rand%0d_key%0d: got %h expected %h", n, i, got_key[i], exp); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_decrypt;
    test_backpressure;
    test_parity;
    test_start_busy;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
